// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, opcode constants and payload record for the CDB producer side.
package cdb_arbiter_pkg;
  localparam int N_SRC  = 3;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int OP_W   = 4;
  localparam int DEST_W = 4;
  localparam int SRC_W  = 2;
  localparam int CNT_W  = 16;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_SD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_LD  = 4'b0011;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DEST_W-1:0] dest;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } payload_t;
endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward with wrap, owns the pointer.
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N     = N_SRC,
  parameter int IDX_W = SRC_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [IDX_W:0]   cand;
  logic             found;
  logic             grant;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_reg} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N))
        cand = cand - (IDX_W+1)'(N);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign grant = en && found && !reset;

  always_comb begin
    gnt = '0;
    if (grant)
      gnt[idx] = 1'b1;
  end

  // Pointer moves just past the winner so the winner becomes lowest priority next time.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant)
      ptr_next = (idx == IDX_W'(N-1)) ? '0 : idx + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      ptr_reg <= '0;
    else
      ptr_reg <= ptr_next;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: round-robin pick among FU results, one registered broadcast entry with back-pressure.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        src_req,
  input  logic [N_SRC*OP_W-1:0]   src_op,
  input  logic [N_SRC*DEST_W-1:0] src_dest,
  input  logic [N_SRC*TAG_W-1:0]  src_tag,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_gnt,
  output logic                    cdb_valid,
  input  logic                    cdb_ready,
  output logic [OP_W-1:0]         cdb_op,
  output logic [DEST_W-1:0]       cdb_dest,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [SRC_W-1:0]        cdb_src,
  output logic [CNT_W-1:0]        cdb_count
);
  logic             valid_reg;
  payload_t         entry_reg;
  logic [SRC_W-1:0] src_reg;
  logic [CNT_W-1:0] count_reg;
  logic             accept;
  logic             granted;
  logic             drain;
  logic [SRC_W-1:0] win_idx;
  payload_t         sel;

  // The entry can take a new result when empty or when it is draining this cycle.
  assign accept = !valid_reg || cdb_ready;
  assign drain  = valid_reg && cdb_ready;

  rr_arbiter #(.N(N_SRC), .IDX_W(SRC_W)) u_rr (
    .clock (clock),
    .reset (reset),
    .en    (accept),
    .req   (src_req),
    .gnt   (src_gnt),
    .idx   (win_idx)
  );

  assign granted = |src_gnt;

  always_comb begin
    sel.op   = src_op  [int'(win_idx)*OP_W   +: OP_W];
    sel.dest = src_dest[int'(win_idx)*DEST_W +: DEST_W];
    sel.tag  = src_tag [int'(win_idx)*TAG_W  +: TAG_W];
    sel.data = src_data[int'(win_idx)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= 1'b0;
      entry_reg <= '0;
      src_reg   <= '0;
      count_reg <= '0;
    end else begin
      if (drain)
        count_reg <= count_reg + 1'b1;
      if (granted) begin
        valid_reg <= 1'b1;
        entry_reg <= sel;
        src_reg   <= win_idx;
      end else if (drain) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign cdb_valid = valid_reg;
  assign cdb_op    = entry_reg.op;
  assign cdb_dest  = entry_reg.dest;
  assign cdb_tag   = entry_reg.tag;
  assign cdb_data  = entry_reg.data;
  assign cdb_src   = src_reg;
  assign cdb_count = count_reg;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table with hand-derived grants, payload scoreboard, reset and wrap sequences.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                    clock;
  logic                    reset;
  logic [N_SRC-1:0]        src_req;
  logic [N_SRC*OP_W-1:0]   src_op;
  logic [N_SRC*DEST_W-1:0] src_dest;
  logic [N_SRC*TAG_W-1:0]  src_tag;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_gnt;
  logic                    cdb_valid;
  logic                    cdb_ready;
  logic [OP_W-1:0]         cdb_op;
  logic [DEST_W-1:0]       cdb_dest;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic [SRC_W-1:0]        cdb_src;
  logic [CNT_W-1:0]        cdb_count;

  cdb_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .src_req   (src_req),
    .src_op    (src_op),
    .src_dest  (src_dest),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .src_gnt   (src_gnt),
    .cdb_valid (cdb_valid),
    .cdb_ready (cdb_ready),
    .cdb_op    (cdb_op),
    .cdb_dest  (cdb_dest),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src),
    .cdb_count (cdb_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] req;
    logic       rdy;
    logic [2:0] gnt;
  } vec_t;

  typedef struct {
    payload_t   p;
    logic [1:0] src;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  int          seq[3];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          total    = 0;
  logic        exp_valid = 1'b0;
  logic [15:0] exp_count = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  // FU0 alternates ADD/SUB, FU1 is LD, FU2 is SD; the other fields move with each new result.
  function automatic payload_t mk(input int fu, input int s);
    payload_t p;
    logic [31:0] sv;
    sv     = 32'(s);
    p.op   = (fu == 0) ? (sv[0] ? OP_SUB : OP_ADD) : ((fu == 1) ? OP_LD : OP_SD);
    p.dest = 4'(2 + fu + s);
    p.tag  = 3'(1 + fu + s);
    p.data = 16'(32'h0007 + fu * 256 + s * 16);
    return p;
  endfunction

  task automatic drive_payloads();
    payload_t p;
    for (int i = 0; i < 3; i++) begin
      p = mk(i, seq[i]);
      src_op[i*OP_W +: OP_W]       = p.op;
      src_dest[i*DEST_W +: DEST_W] = p.dest;
      src_tag[i*TAG_W +: TAG_W]    = p.tag;
      src_data[i*DATA_W +: DATA_W] = p.data;
    end
  endtask

  task automatic step(input logic [2:0] req, input logic rdy, input logic [2:0] exp_gnt,
                      input bit verbose);
    exp_t e;
    int   w;
    @(negedge clock);
    src_req   = req;
    cdb_ready = rdy;
    drive_payloads();
    #1;
    check("count", 32'(cdb_count), 32'(exp_count));
    check("valid", 32'(cdb_valid), 32'(exp_valid));
    check("gnt",   32'(src_gnt),   32'(exp_gnt));
    if (verbose)
      $display("step req=%b rdy=%b gnt=%b valid=%b src=%0d data=%h count=%0d",
               req, rdy, src_gnt, cdb_valid, cdb_src, cdb_data, cdb_count);
    if (exp_valid && rdy) begin
      if (sb.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("cdb_op",   32'(cdb_op),   32'(e.p.op));
        check("cdb_dest", 32'(cdb_dest), 32'(e.p.dest));
        check("cdb_tag",  32'(cdb_tag),  32'(e.p.tag));
        check("cdb_data", 32'(cdb_data), 32'(e.p.data));
        check("cdb_src",  32'(cdb_src),  32'(e.src));
      end
      exp_count = exp_count + 16'd1;
      total++;
    end
    if (exp_gnt != 3'b000) begin
      w = exp_gnt[0] ? 0 : (exp_gnt[1] ? 1 : 2);
      e.p   = mk(w, seq[w]);
      e.src = 2'(w);
      sb.push_back(e);
      seq[w]++;
      exp_valid = 1'b1;
    end else if (rdy) begin
      exp_valid = 1'b0;
    end
  endtask

  // Reset asserted with all FUs requesting; no grant may appear and the entry must be discarded.
  task automatic reset_seq();
    @(negedge clock);
    reset     = 1'b1;
    src_req   = 3'b111;
    cdb_ready = 1'b0;
    #1;
    check("rst_gnt", 32'(src_gnt), 32'd0);
    @(negedge clock);
    reset   = 1'b0;
    src_req = 3'b000;
    #1;
    check("rst_valid", 32'(cdb_valid), 32'd0);
    check("rst_count", 32'(cdb_count), 32'd0);
    $display("reset valid=%b count=%0d", cdb_valid, cdb_count);
    sb.delete();
    exp_valid = 1'b0;
    exp_count = 16'h0;
  endtask

  function automatic vec_t v(input logic [2:0] req, input logic rdy, input logic [2:0] gnt);
    vec_t x;
    x.req = req; x.rdy = rdy; x.gnt = gnt;
    return x;
  endfunction

  initial begin
    int r;
    for (int i = 0; i < 3; i++) seq[i] = 0;

    // single request, then round-robin with all three, back-pressure, pointer wrap
    vecs.push_back(v(3'b001, 1'b1, 3'b001));
    vecs.push_back(v(3'b000, 1'b1, 3'b000));
    vecs.push_back(v(3'b000, 1'b1, 3'b000));
    vecs.push_back(v(3'b111, 1'b1, 3'b010));
    vecs.push_back(v(3'b111, 1'b1, 3'b100));
    vecs.push_back(v(3'b111, 1'b1, 3'b001));
    vecs.push_back(v(3'b111, 1'b1, 3'b010));
    vecs.push_back(v(3'b111, 1'b1, 3'b100));
    vecs.push_back(v(3'b111, 1'b1, 3'b001));
    vecs.push_back(v(3'b000, 1'b1, 3'b000));
    vecs.push_back(v(3'b001, 1'b0, 3'b001));
    vecs.push_back(v(3'b010, 1'b0, 3'b000));
    vecs.push_back(v(3'b010, 1'b0, 3'b000));
    vecs.push_back(v(3'b010, 1'b0, 3'b000));
    vecs.push_back(v(3'b010, 1'b1, 3'b010));
    vecs.push_back(v(3'b000, 1'b1, 3'b000));
    vecs.push_back(v(3'b011, 1'b1, 3'b001));
    vecs.push_back(v(3'b011, 1'b1, 3'b010));
    vecs.push_back(v(3'b000, 1'b1, 3'b000));
    vecs.push_back(v(3'b111, 1'b1, 3'b100));

    reset     = 1'b1;
    src_req   = 3'b111;
    cdb_ready = 1'b1;
    drive_payloads();
    #1;
    check("init_gnt", 32'(src_gnt), 32'd0);
    repeat (2) @(negedge clock);
    #1;
    check("init_valid", 32'(cdb_valid), 32'd0);
    check("init_count", 32'(cdb_count), 32'd0);
    check("init_data",  32'(cdb_data),  32'd0);
    check("init_src",   32'(cdb_src),   32'd0);
    check("init_gnt2",  32'(src_gnt),   32'd0);
    reset   = 1'b0;
    src_req = 3'b000;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].req, vecs[i].rdy, vecs[i].gnt, 1'b1);

    // an entry is pending here; reset must drop it and return the pointer to FU0
    reset_seq();
    step(3'b111, 1'b1, 3'b001, 1'b1);
    step(3'b000, 1'b1, 3'b000, 1'b1);
    step(3'b000, 1'b1, 3'b000, 1'b1);

    reset_seq();
    total = 0;
    r = 0;
    while (total < 65535) begin
      step(3'b111, 1'b1, 3'(3'b001 << r), 1'b0);
      r = (r == 2) ? 0 : r + 1;
    end
    step(3'b000, 1'b1, 3'b000, 1'b1);
    check("count_ffff", 32'(cdb_count), 32'h0000FFFF);
    step(3'b000, 1'b1, 3'b000, 1'b1);
    check("count_wrap", 32'(cdb_count), 32'h00000000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
